// File: rtl/line_card_ingress_scheduler_pkg.sv
// Line card shared types.
// Pointer type, scheduler states, default port count.
package line_card_ingress_scheduler_pkg;

  localparam int LC_NUM_PORTS = 24;
  localparam int LC_PTR_BITS  = 13;

  typedef logic [LC_PTR_BITS-1:0] ingress_ptr_t;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    OFFER,
    BUSY
  } sched_state_t;

endpackage

// File: rtl/round_robin_encoder.sv
// Rotating priority encoder.
// Lowest pending port at or after last+1 wins.
module round_robin_encoder #(
  parameter int N  = 24,
  parameter int PB = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [PB-1:0] last,
  output logic [PB-1:0] winner,
  output logic          any
);

  int          idx;
  logic [PB-1:0] sel;

  // scan from farthest to nearest so the nearest hit is kept
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(last) + 1 + k) % N;
      sel = PB'(idx);
      if (pending[sel]) begin
        winner = sel;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_card_ingress_scheduler.sv
// Round-robin read-port scheduler for ingress FIFOs.
// One whole-frame grant at a time, with a watchdog.
module line_card_ingress_scheduler
  import line_card_ingress_scheduler_pkg::*;
#(
  parameter int NUM_PORTS      = LC_NUM_PORTS,
  parameter int PTR_BITS       = LC_PTR_BITS,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int PORT_BITS     = $clog2(NUM_PORTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0][PTR_BITS-1:0] wr_ptr_committed,
  input  logic [NUM_PORTS-1:0][PTR_BITS-1:0] rd_ptr,
  input  logic [NUM_PORTS-1:0]               rd_ptr_reset,
  output logic                               grant_valid,
  output logic [PORT_BITS-1:0]               grant_port,
  input  logic                               grant_ready,
  input  logic                               frame_done,
  output logic                               busy,
  output logic                               timeout_err,
  output logic [PORT_BITS-1:0]               timeout_port
);

  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_BITS-1:0] WD_LAST =
    WD_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [PORT_BITS-1:0] LAST_INIT =
    PORT_BITS'(NUM_PORTS - 1);

  sched_state_t         state_q, state_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic [PORT_BITS-1:0] last_port_q, last_port_d;
  logic [PORT_BITS-1:0] grant_port_q, grant_port_d;
  logic [WD_BITS-1:0]   wd_q, wd_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [PORT_BITS-1:0] timeout_port_q, timeout_port_d;

  logic [PORT_BITS-1:0] rr_winner;
  logic                 rr_any;

  round_robin_encoder #(
    .N  (NUM_PORTS),
    .PB (PORT_BITS)
  ) u_rr (
    .pending (pending_q),
    .last    (last_port_q),
    .winner  (rr_winner),
    .any     (rr_any)
  );

  // nonempty and not held in reset; full wrap differs in MSB
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pending_d[i] = (wr_ptr_committed[i] != rd_ptr[i])
                     && !rd_ptr_reset[i];
    end
  end

  // next state, grant bookkeeping and watchdog
  always_comb begin
    state_d        = state_q;
    last_port_d    = last_port_q;
    grant_port_d   = grant_port_q;
    wd_d           = wd_q;
    timeout_err_d  = 1'b0;
    timeout_port_d = timeout_port_q;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) state_d = ARB;
      end
      ARB: begin
        if (rr_any) begin
          grant_port_d = rr_winner;
          state_d      = OFFER;
        end else begin
          state_d = IDLE;
        end
      end
      OFFER: begin
        if (grant_ready) begin
          state_d = BUSY;
          wd_d    = '0;
        end else if (rd_ptr_reset[grant_port_q]) begin
          state_d = ARB;
        end
      end
      BUSY: begin
        wd_d = wd_q + WD_BITS'(1);
        if (frame_done) begin
          last_port_d = grant_port_q;
          state_d     = (|pending_q) ? ARB : IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d  = 1'b1;
          timeout_port_d = grant_port_q;
          last_port_d    = grant_port_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      last_port_q    <= LAST_INIT;
      grant_port_q   <= '0;
      wd_q           <= '0;
      timeout_err_q  <= 1'b0;
      timeout_port_q <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      last_port_q    <= last_port_d;
      grant_port_q   <= grant_port_d;
      wd_q           <= wd_d;
      timeout_err_q  <= timeout_err_d;
      timeout_port_q <= timeout_port_d;
    end
  end

  assign grant_valid  = (state_q == OFFER);
  assign busy         = (state_q == BUSY);
  assign grant_port   = grant_port_q;
  assign timeout_err  = timeout_err_q;
  assign timeout_port = timeout_port_q;

endmodule

// File: tb/tb_line_card_ingress_scheduler.sv
// Bench for the ingress scheduler.
// Expected grant ports queued at stimulus, popped at grant.
module tb_line_card_ingress_scheduler;

  localparam int NP = 24;
  localparam int PB = 13;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NP-1:0][PB-1:0]  wr = '0;
  logic [NP-1:0][PB-1:0]  rd = '0;
  logic [NP-1:0]          prst = '0;
  logic                   grant_valid;
  logic [4:0]             grant_port;
  logic                   grant_ready = 1'b0;
  logic                   frame_done = 1'b0;
  logic                   busy;
  logic                   timeout_err;
  logic [4:0]             timeout_port;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  line_card_ingress_scheduler #(
    .NUM_PORTS      (NP),
    .PTR_BITS       (PB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_ptr_committed (wr),
    .rd_ptr           (rd),
    .rd_ptr_reset     (prst),
    .grant_valid      (grant_valid),
    .grant_port       (grant_port),
    .grant_ready      (grant_ready),
    .frame_done       (frame_done),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .timeout_port     (timeout_port)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    grant_ready = 1'b0;
    frame_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pop_exp(output int p);
    p = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    int w;
    w = 0;
    while (grant_valid !== 1'b1 && w < 60) begin
      step();
      w++;
    end
    ok = (grant_valid === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_wait grant_valid=%b want 1", nm, grant_valid);
    end
  endtask

  task automatic check_port(input string nm);
    int e;
    pop_exp(e);
    checks++;
    if (int'(grant_port) !== e) begin
      failures++;
      $display("FAIL %s_port got %0d want %0d", nm, grant_port, e);
    end
  endtask

  // serve n frames of len busy cycles; last frame drains all FIFOs
  task automatic serve(input string nm, input int n, input int len,
                       input bit chk_gap);
    int w, gap, e;
    gap = 0;
    for (int f = 0; f < n; f++) begin
      grant_ready = 1'b1;
      w = 0;
      while (grant_valid !== 1'b1 && w < 60) begin
        step();
        w++;
      end
      checks++;
      if (grant_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_wait f=%0d grant_valid=%b want 1",
                 nm, f, grant_valid);
        grant_ready = 1'b0;
        return;
      end
      pop_exp(e);
      checks++;
      if (int'(grant_port) !== e) begin
        failures++;
        $display("FAIL %s_port f=%0d got %0d want %0d",
                 nm, f, grant_port, e);
      end
      if (chk_gap && f > 0) begin
        checks++;
        if (gap + w != 2) begin
          failures++;
          $display("FAIL %s_gap f=%0d got %0d want 2", nm, f, gap + w);
        end
      end
      step();
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy f=%0d got %b want 1", nm, f, busy);
      end
      repeat (len - 1) step();
      if (f == n - 1) begin
        grant_ready = 1'b0;
        rd = wr;
      end
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      gap = 1;
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({grant_valid, busy, timeout_err} !== 3'b000 ||
        grant_port !== 5'd0 || timeout_port !== 5'd0) begin
      failures++;
      $display("FAIL %s got v=%b b=%b te=%b gp=%0d tp=%0d want all 0",
               nm, grant_valid, busy, timeout_err, grant_port,
               timeout_port);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();
    check_idle_outputs("reset_release");
  endtask

  task automatic test_latency();
    bit ok;
    grant_ready = 1'b1;
    wr[5] = 13'h010;
    exp_q.push_back(5);
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++;
      if (grant_valid !== 1'b0) begin
        failures++;
        $display("FAIL lat_early c=%0d got %b want 0", c, grant_valid);
      end
    end
    step();
    checks++;
    if (grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL lat_plus3 grant_valid=%b want 1", grant_valid);
    end
    wait_valid("lat", ok);
    check_port("lat");
    step();
    checks++;
    if (busy !== 1'b1 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_busy busy=%b v=%b want 1 0", busy, grant_valid);
    end
    grant_ready = 1'b0;
    rd = wr;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL lat_done busy=%b want 0", busy);
    end
    repeat (4) step();
  endtask

  task automatic test_round_robin();
    apply_reset();
    wr[3]  = wr[3]  + 13'h20;
    wr[7]  = wr[7]  + 13'h20;
    wr[20] = wr[20] + 13'h20;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(3);
      exp_q.push_back(7);
      exp_q.push_back(20);
    end
    serve("rr", 6, 10, 1'b1);
    repeat (4) step();
  endtask

  task automatic test_wrap();
    int seen;
    rd[9] = 13'h0000;
    wr[9] = 13'h1000;
    exp_q.push_back(9);
    serve("wrap", 1, 5, 1'b0);
    rd[9] = 13'h0123;
    wr[9] = 13'h0123;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      frame_done = (c == 5);
      step();
      if (grant_valid === 1'b1 || busy === 1'b1) seen++;
    end
    frame_done = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL equal_ptr got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_port_reset();
    bit ok;
    int bad;
    grant_ready = 1'b0;
    wr[4] = wr[4] + 13'h8;
    exp_q.push_back(4);
    wait_valid("prst", ok);
    check_port("prst");
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (grant_valid !== 1'b1 || grant_port !== 5'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL prst_stable got %0d unstable want 0", bad);
    end
    prst[4] = 1'b1;
    wr[11] = wr[11] + 13'h1;
    step();
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL prst_drop grant_valid=%b want 0", grant_valid);
    end
    exp_q.push_back(11);
    serve("prst_next", 1, 4, 1'b0);
    prst[4] = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    wr[2] = wr[2] + 13'h1;
    wr[3] = wr[3] + 13'h1;
    grant_ready = 1'b1;
    exp_q.push_back(2);
    wait_valid("to", ok);
    check_port("to");
    step();
    grant_ready = 1'b0;
    k = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (k != TO) begin
      failures++;
      $display("FAIL to_cycles got %0d want %0d", k, TO);
    end
    checks++;
    if (timeout_port !== 5'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_port got %0d busy=%b want 2 0",
               timeout_port, busy);
    end
    step();
    checks++;
    if (timeout_err !== 1'b0 || timeout_port !== 5'd2) begin
      failures++;
      $display("FAIL to_pulse te=%b tp=%0d want 0 2",
               timeout_err, timeout_port);
    end
    exp_q.push_back(3);
    serve("to_next", 1, 4, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_reset_busy();
    bit ok;
    wr[1]  = wr[1]  + 13'h4;
    wr[15] = wr[15] + 13'h4;
    grant_ready = 1'b1;
    exp_q.push_back(15);
    wait_valid("rb", ok);
    check_port("rb");
    step();
    grant_ready = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rb_busy got %b want 1", busy);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
    check_idle_outputs("rb_rst");
    rst = 1'b0;
    exp_q.push_back(1);
    serve("rb_after", 1, 4, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_wrap();
    test_port_reset();
    test_timeout();
    test_reset_busy();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
